// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: pops an async FIFO read port into a 2-entry buffer and emits a framed valid/ready stream.
// Optional word-count statistics are enabled by defining RD_STREAM_STATS_EN.
module fifo_rd_streamer #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
`ifdef RD_STREAM_STATS_EN
  output logic [CNT_W-1:0] word_cnt,
`endif
  output logic             busy
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [DSIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             pop;
  // rinc is gated by reset so no FIFO word is lost while the buffer is being cleared
  assign rinc    = rrst_n && en && !rempty && (cnt_q != 2'd2);
  assign m_valid = cnt_q != 2'd0;
  assign m_data  = buf0_q;
  assign m_last  = m_valid && (beat_q == LAST_BEAT);
  assign busy    = state_q != IDLE;
  assign pop     = m_valid && m_ready;
  always_comb begin
    cnt_d   = cnt_q + {1'b0, rinc} - {1'b0, pop};
    buf0_d  = (pop && cnt_q == 2'd2) ? buf1_q : (rinc && (cnt_q == 2'd0 || pop)) ? rdata : buf0_q;
    buf1_d  = (rinc && cnt_q == 2'd1 && !pop) ? rdata : buf1_q;
    beat_d  = !pop ? beat_q : (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    state_d = en ? ACTIVE : (state_q == IDLE || cnt_d == 2'd0) ? IDLE : DRAIN;
  end
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      beat_q  <= beat_d;
    end
  end
`ifdef RD_STREAM_STATS_EN
  logic [CNT_W-1:0] word_cnt_q;
  logic             last_seen_q;
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      word_cnt_q  <= '0;
      last_seen_q <= 1'b0;
    end else begin
      if (pop && !(&word_cnt_q)) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (pop && m_last) last_seen_q <= 1'b1;
    end
  end
  assign word_cnt = word_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed checks of fifo_rd_streamer against a simple fall-through FIFO model.
// Define RD_STREAM_STATS_EN to also check the saturating word counter.
module tb_fifo_rd_streamer;
  logic       rclk = 1'b0;
  logic       rrst_n, en, rempty, rinc, m_valid, m_last, m_ready, busy;
  logic [7:0] rdata, m_data;
`ifdef RD_STREAM_STATS_EN
  logic [3:0] word_cnt;
`endif
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rinc_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         r0;
  fifo_rd_streamer #(.DSIZE(8), .PKT_LEN(4), .CNT_W(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
`ifdef RD_STREAM_STATS_EN
    .word_cnt(word_cnt),
`endif
    .busy(busy)
  );
  always #5 rclk = ~rclk;
  assign rempty = rd_ptr == wr_ptr;
  assign rdata  = mem[rd_ptr[5:0]];
  always @(posedge rclk) begin
    if (rinc && !rempty) rd_ptr <= rd_ptr + 1;
    if (rinc) rinc_cnt <= rinc_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask
  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"}, m_data, d);
    check({tag, "_last"}, m_last, l);
  endtask
  initial begin
    logic [7:0] v1 [4] = '{8'h10, 8'h30, 8'h50, 8'h70};
    logic [7:0] v2 [5] = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90};
    rrst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge rclk);
    check("rst_rinc", rinc, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
`ifdef RD_STREAM_STATS_EN
    check("rst_wcnt", word_cnt, 0);
`endif
    rrst_n = 1'b1;
    // full-rate streaming with framing
    for (int i = 0; i < 4; i++) push(v1[i]);
    en = 1'b1; m_ready = 1'b1;
    r0 = rinc_cnt;
    #1 check("t1_rinc0", rinc, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      expect_beat("t1", v1[i], i == 3);
    end
    @(negedge rclk);
    check("t1_idle_valid", m_valid, 0);
    check("t1_pulses", rinc_cnt - r0, 4);
    // backpressure: buffer fills to two then holds
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(v2[i]);
    r0 = rinc_cnt;
    repeat (4) begin
      @(negedge rclk);
      expect_beat("t2_hold", 8'h10, 1'b0);
    end
    check("t2_pulses", rinc_cnt - r0, 2);
    check("t2_rinc_full", rinc, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_beat("t2_out", v2[i], i == 3);
      @(negedge rclk);
    end
    check("t2_empty", m_valid, 0);
    // drain on en drop, packet resumes on re-enable
    rrst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    check("t3_rst_busy", busy, 0);
    for (int i = 1; i <= 6; i++) push(8'(i * 8'h11));
    en = 1'b1; m_ready = 1'b1;
    #1 check("t3_rinc0", rinc, 1);
    @(negedge rclk); expect_beat("t3_w0", 8'h11, 1'b0);
    @(negedge rclk); expect_beat("t3_w1", 8'h22, 1'b0);
    @(negedge rclk); expect_beat("t3_w2", 8'h33, 1'b0);
    en = 1'b0; m_ready = 1'b0;
    #1 check("t3_rinc_off", rinc, 0);
    @(negedge rclk);
    check("t3_drain_busy", busy, 1);
    check("t3_drain_rinc", rinc, 0);
    expect_beat("t3_drain", 8'h33, 1'b0);
    m_ready = 1'b1;
    @(negedge rclk);
    check("t3_idle_busy", busy, 0);
    check("t3_idle_valid", m_valid, 0);
    en = 1'b1;
    #1 check("t3_rinc_on", rinc, 1);
    @(negedge rclk); expect_beat("t3_w3", 8'h44, 1'b1);
    @(negedge rclk); expect_beat("t3_w4", 8'h55, 1'b0);
    @(negedge rclk); expect_beat("t3_w5", 8'h66, 1'b0);
    @(negedge rclk);
    check("t3_done", m_valid, 0);
    // enabled but FIFO empty
    repeat (3) begin
      @(negedge rclk);
      check("t4_rinc", rinc, 0);
      check("t4_valid", m_valid, 0);
      check("t4_busy", busy, 1);
    end
    // reset with two words buffered
    m_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (2) @(negedge rclk);
    expect_beat("t5_full", 8'hA1, 1'b0);
    check("t5_rinc_full", rinc, 0);
    push(8'hB1); push(8'hB2); push(8'hB3);
    rrst_n = 1'b0;
    #1 check("t5_rinc_rst", rinc, 0);
    @(negedge rclk);
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_busy", busy, 0);
    rrst_n = 1'b1; m_ready = 1'b1;
    @(negedge rclk); expect_beat("t5_w0", 8'hA3, 1'b0);
    @(negedge rclk); expect_beat("t5_w1", 8'hB1, 1'b0);
    @(negedge rclk); expect_beat("t5_w2", 8'hB2, 1'b0);
    @(negedge rclk); expect_beat("t5_w3", 8'hB3, 1'b1);
    @(negedge rclk);
    check("t5_done", m_valid, 0);
`ifdef RD_STREAM_STATS_EN
    check("t6_wcnt4", word_cnt, 4);
    for (int i = 0; i < 20; i++) push(8'(i));
    repeat (24) @(negedge rclk);
    check("t6_wcnt_sat", word_cnt, 15);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
